// File: rtl/acc_alu_if.sv
// acc_alu_if: command/result handshake bundle for acc_alu.
//   master: drives commands and consumes results (bench / upstream datapath).
//   slave : the accumulator engine.
interface acc_alu_if #(
    parameter int WIDTH = 64,
    parameter int CNT_W = 16
);
    localparam int SH_W = $clog2(WIDTH);

    // Command channel
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       mode;
    logic [WIDTH-1:0] b;
    logic [SH_W-1:0]  shamt;

    // Result channel
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] y;
    logic             err;
    logic [CNT_W-1:0] op_cnt;

    modport master (
        output in_valid, mode, b, shamt, out_ready,
        input  in_ready, out_valid, y, err, op_cnt
    );

    modport slave (
        input  in_valid, mode, b, shamt, out_ready,
        output in_ready, out_valid, y, err, op_cnt
    );
endinterface

// File: rtl/acc_alu.sv
// acc_alu: registered WIDTH-bit accumulator applying one bitwise/rotate
// operation per accepted command (acc <= f(acc, b)), with a single-entry
// valid/ready result register and a saturating accepted-command counter.
// Optional feature: define ACC_ALU_ZEROIZE_EN to add a synchronous
// zeroize input that wipes all state and blocks acceptance that cycle.
module acc_alu #(
    parameter int               WIDTH     = 64,
    parameter int               CNT_W     = 16,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic     clk,
    input  logic     rst_n,
`ifdef ACC_ALU_ZEROIZE_EN
    input  logic     zeroize,
`endif
    acc_alu_if.slave bus
);
    localparam int SH_W = $clog2(WIDTH);

    typedef enum logic [2:0] {
        MODE_XOR   = 3'd0,
        MODE_ANDN  = 3'd1,
        MODE_NOT   = 3'd2,
        MODE_LOAD  = 3'd3,
        MODE_ROTL  = 3'd4,
        MODE_CHI   = 3'd5,
        MODE_CLEAR = 3'd6,
        MODE_RSVD  = 3'd7
    } mode_e;

    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] next_acc;
    logic             out_valid_q;
    logic             err_q;
    logic [CNT_W-1:0] op_cnt_q;
    logic             zap;
    logic             accept;

    // Left rotate: the upper half of the doubled word shifted left is the
    // rotated value, so shamt=0 and full wrap need no special casing.
    function automatic logic [WIDTH-1:0] rotl(input logic [WIDTH-1:0] v,
                                              input logic [SH_W-1:0]  s);
        logic [2*WIDTH-1:0] t;
        t = {v, v} << s;
        return t[2*WIDTH-1:WIDTH];
    endfunction

`ifdef ACC_ALU_ZEROIZE_EN
    assign zap = zeroize;
`else
    assign zap = 1'b0;
`endif

    // Ready whenever the result slot is empty or being drained this cycle;
    // zeroize blocks acceptance so a wiped engine never absorbs a command.
    assign bus.in_ready = (!out_valid_q || bus.out_ready) && !zap;
    assign accept       = bus.in_valid && bus.in_ready;

    assign bus.out_valid = out_valid_q;
    assign bus.y         = acc;
    assign bus.err       = err_q;
    assign bus.op_cnt    = op_cnt_q;

    // Next accumulator value for the presented command.
    always_comb begin
        // NOTE: defaulting every always_comb output first keeps the
        // decode free of inferred latches for any mode encoding.
        next_acc = acc;
        case (mode_e'(bus.mode))
            MODE_XOR:   next_acc = acc ^ bus.b;
            MODE_ANDN:  next_acc = ~acc & bus.b;
            MODE_NOT:   next_acc = ~acc;
            MODE_LOAD:  next_acc = bus.b;
            MODE_ROTL:  next_acc = rotl(acc, bus.shamt);
            MODE_CHI:   next_acc = acc ^ (~rotl(acc, SH_W'(1)) & rotl(acc, SH_W'(2)));
            MODE_CLEAR: next_acc = '0;
            MODE_RSVD:  next_acc = acc;
            default:    next_acc = acc;
        endcase
    end

    // Accumulator, result handshake, error flag and saturating counter.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: reset clears every state flop, so a pending result is
        // discarded the instant rst_n falls.
        if (!rst_n) begin
            acc         <= RESET_VAL;
            out_valid_q <= 1'b0;
            err_q       <= 1'b0;
            op_cnt_q    <= '0;
        end else if (zap) begin
            acc         <= '0;
            out_valid_q <= 1'b0;
            err_q       <= 1'b0;
            op_cnt_q    <= '0;
        end else if (accept) begin
            // NOTE: non-blocking assignments so every flop samples the
            // pre-edge acc/op_cnt, independent of statement order.
            acc         <= next_acc;
            out_valid_q <= 1'b1;
            err_q       <= (bus.mode == MODE_RSVD);
            if (op_cnt_q != '1) begin
                op_cnt_q <= op_cnt_q + 1'b1;
            end
        end else if (bus.out_ready) begin
            out_valid_q <= 1'b0;
        end
    end
endmodule

// File: tb/tb_acc_alu.sv
// tb_acc_alu: directed self-checking bench for acc_alu.
// dut  : default parameters (WIDTH=64, CNT_W=16, RESET_VAL=0).
// dut2 : CNT_W=2, RESET_VAL=64'hDEAD for counter saturation / reset value.
module tb_acc_alu;
    localparam logic [2:0] M_XOR   = 3'd0;
    localparam logic [2:0] M_ANDN  = 3'd1;
    localparam logic [2:0] M_NOT   = 3'd2;
    localparam logic [2:0] M_LOAD  = 3'd3;
    localparam logic [2:0] M_ROTL  = 3'd4;
    localparam logic [2:0] M_CHI   = 3'd5;
    localparam logic [2:0] M_CLEAR = 3'd6;
    localparam logic [2:0] M_RSVD  = 3'd7;

    logic clk;
    logic rst_n;
    logic zeroize;
    int   total;
    int   bad;

    acc_alu_if #(.WIDTH(64), .CNT_W(16)) bus  ();
    acc_alu_if #(.WIDTH(64), .CNT_W(2))  bus2 ();

    acc_alu #(.WIDTH(64), .CNT_W(16), .RESET_VAL(64'h0)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
`ifdef ACC_ALU_ZEROIZE_EN
        .zeroize (zeroize),
`endif
        .bus     (bus.slave)
    );

    acc_alu #(.WIDTH(64), .CNT_W(2), .RESET_VAL(64'hDEAD)) dut2 (
        .clk     (clk),
        .rst_n   (rst_n),
`ifdef ACC_ALU_ZEROIZE_EN
        .zeroize (zeroize),
`endif
        .bus     (bus2.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Present one command for exactly one edge, then sample after the edge.
    task automatic send(input logic [2:0] m, input logic [63:0] bv, input logic [5:0] sh);
        bus.in_valid = 1'b1;
        bus.mode     = m;
        bus.b        = bv;
        bus.shamt    = sh;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic idle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        zeroize        = 1'b0;
        rst_n          = 1'b0;
        bus.in_valid   = 1'b0;
        bus.mode       = 3'd0;
        bus.b          = '0;
        bus.shamt      = '0;
        bus.out_ready  = 1'b1;
        bus2.in_valid  = 1'b0;
        bus2.mode      = 3'd0;
        bus2.b         = '0;
        bus2.shamt     = '0;
        bus2.out_ready = 1'b1;

        // Reset state
        #12;
        check("rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("rst_y",         bus.y,              64'd0);
        check("rst_err",       64'(bus.err),       64'd0);
        check("rst_op_cnt",    64'(bus.op_cnt),    64'd0);
        check("rst_in_ready",  64'(bus.in_ready),  64'd1);
        check("rst_y_dut2",    bus2.y,             64'hDEAD);
        @(negedge clk);
        rst_n = 1'b1;

        // LOAD then XOR
        send(M_LOAD, 64'hF0F0_0000_0000_000F, 6'd0);
        check("load_y",         bus.y,              64'hF0F0_0000_0000_000F);
        check("load_out_valid", 64'(bus.out_valid), 64'd1);
        send(M_XOR, 64'hFFFF_0000_0000_0000, 6'd0);
        check("xor_y",      bus.y,           64'h0F0F_0000_0000_000F);
        check("xor_op_cnt", 64'(bus.op_cnt), 64'd2);
        check("xor_err",    64'(bus.err),    64'd0);
        idle();
        check("drain_out_valid", 64'(bus.out_valid), 64'd0);
        check("drain_y_hold",    bus.y,              64'h0F0F_0000_0000_000F);

        // ROTL: MSB wraps, shamt=0 no-op, shamt=63 is rotate right by one
        send(M_LOAD, 64'h8000_0000_0000_0001, 6'd0);
        send(M_ROTL, 64'hFFFF_FFFF_FFFF_FFFF, 6'd1);
        check("rotl1_y", bus.y, 64'h0000_0000_0000_0003);
        send(M_ROTL, 64'h0, 6'd0);
        check("rotl0_y", bus.y, 64'h0000_0000_0000_0003);
        send(M_ROTL, 64'h0, 6'd63);
        check("rotl63_y", bus.y, 64'h8000_0000_0000_0001);

        // CHI: 0 -> 0; 1 -> 1 ^ (~2 & 4) = 5; 2 -> 2 ^ (~4 & 8) = A
        send(M_CLEAR, 64'h1234, 6'd0);
        check("clear_y", bus.y, 64'h0);
        send(M_CHI, 64'h0, 6'd0);
        check("chi0_y", bus.y, 64'h0);
        send(M_LOAD, 64'h1, 6'd0);
        send(M_CHI, 64'h0, 6'd0);
        check("chi1_y", bus.y, 64'h5);
        send(M_LOAD, 64'h2, 6'd0);
        send(M_CHI, 64'h0, 6'd0);
        check("chi2_y", bus.y, 64'hA);

        // Reserved mode, then NOT clears err; ANDN on the result
        send(M_LOAD, 64'h55, 6'd0);
        send(M_RSVD, 64'hFFFF, 6'd5);
        check("rsvd_y",   bus.y,        64'h55);
        check("rsvd_err", 64'(bus.err), 64'd1);
        send(M_NOT, 64'h1234, 6'd0);
        check("not_y",   bus.y,        64'hFFFF_FFFF_FFFF_FFAA);
        check("not_err", 64'(bus.err), 64'd0);
        send(M_ANDN, 64'hFF, 6'd0);
        check("andn_y", bus.y, 64'h55);
        idle();

        // Backpressure: first result holds, remaining commands wait
        bus.out_ready = 1'b0;
        send(M_LOAD, 64'h11, 6'd0);
        check("bp_first_y",  bus.y,             64'h11);
        check("bp_in_ready", 64'(bus.in_ready), 64'd0);
        bus.in_valid = 1'b1;
        bus.mode     = M_XOR;
        bus.b        = 64'h22;
        idle();
        idle();
        check("bp_hold_y",         bus.y,              64'h11);
        check("bp_hold_out_valid", 64'(bus.out_valid), 64'd1);
        check("bp_hold_in_ready",  64'(bus.in_ready),  64'd0);
        bus.out_ready = 1'b1;
        #1;
        check("bp_release_in_ready", 64'(bus.in_ready), 64'd1);
        @(posedge clk);
        #1;
        check("bp_second_y",         bus.y,              64'h33);
        check("bp_second_out_valid", 64'(bus.out_valid), 64'd1);
        bus.b = 64'h0F;
        @(posedge clk);
        #1;
        check("bp_third_y", bus.y, 64'h3C);
        bus.in_valid = 1'b0;
        check("bp_op_cnt", 64'(bus.op_cnt), 64'd19);
        idle();
        check("bp_drain_out_valid", 64'(bus.out_valid), 64'd0);

        // Saturating counter on the CNT_W=2 instance
        for (int i = 0; i < 5; i++) begin
            bus2.in_valid = 1'b1;
            bus2.mode     = M_LOAD;
            bus2.b        = 64'(i + 100);
            @(posedge clk);
            #1;
            check($sformatf("sat_op_cnt_%0d", i), 64'(bus2.op_cnt), (i >= 2) ? 64'd3 : 64'(i + 1));
        end
        bus2.in_valid = 1'b0;
        check("sat_y", bus2.y, 64'd104);

        // Reset while a result is pending
        bus.out_ready = 1'b0;
        send(M_LOAD, 64'hAB, 6'd0);
        check("pre_rst_out_valid", 64'(bus.out_valid), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_out_valid", 64'(bus.out_valid), 64'd0);
        check("midrst_y",         bus.y,              64'd0);
        check("midrst_op_cnt",    64'(bus.op_cnt),    64'd0);
        check("midrst_y_dut2",    bus2.y,             64'hDEAD);
        check("midrst_cnt_dut2",  64'(bus2.op_cnt),   64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        bus.out_ready = 1'b1;

`ifdef ACC_ALU_ZEROIZE_EN
        // Zeroize beats a pending command and a held result
        send(M_LOAD, 64'h77, 6'd0);
        bus.out_ready = 1'b0;
        send(M_RSVD, 64'h0, 6'd0);
        bus.in_valid = 1'b1;
        bus.mode     = M_LOAD;
        bus.b        = 64'h99;
        bus.out_ready = 1'b1;
        zeroize      = 1'b1;
        #1;
        check("zz_in_ready", 64'(bus.in_ready), 64'd0);
        @(posedge clk);
        #1;
        zeroize      = 1'b0;
        bus.in_valid = 1'b0;
        check("zz_y",         bus.y,              64'd0);
        check("zz_out_valid", 64'(bus.out_valid), 64'd0);
        check("zz_err",       64'(bus.err),       64'd0);
        check("zz_op_cnt",    64'(bus.op_cnt),    64'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
